// File: rtl/frame_transmitter_pkg.sv
// Shared definitions for the serial packet framer: line levels, FSM encodings, width helper.
package tx_defs;

  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;

  // Per-byte serialiser states
  typedef enum logic [2:0] {
    BIT_IDLE,
    BIT_START,
    BIT_DATA,
    BIT_PARITY,
    BIT_STOP
  } bit_state_t;

  // Packet-level states
  typedef enum logic [1:0] {
    PKT_IDLE,
    PKT_SEND,
    PKT_GAP
  } pkt_state_t;

  // Bits needed to hold a byte count of 0..n
  function automatic int unsigned len_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/frame_transmitter_if.sv
// Packet request / serial status bundle between a producer and the framer.
interface frame_transmitter_if
  import tx_defs::*;
#(
  parameter int unsigned DATA_BYTES = 8
);
  localparam int unsigned LEN_W = len_width(DATA_BYTES);

  logic                    send;
  logic [LEN_W-1:0]        len;
  logic [8*DATA_BYTES-1:0] data;
  logic                    ready;
  logic                    busy;
  logic                    transmission;
  logic                    done;
  logic                    out_data;

  modport master (
    output send, len, data,
    input  ready, busy, transmission, done, out_data
  );

  modport slave (
    input  send, len, data,
    output ready, busy, transmission, done, out_data
  );
endinterface

// File: rtl/frame_transmitter_serial_byte_tx.sv
// Serialises one byte per start pulse: start bit, 8 data bits LSB-first, optional even parity, stop bit(s).
module serial_byte_tx
  import tx_defs::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned PARITY_EN    = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] byte_in,
  output logic       line,
  output logic       frame_busy,
  output logic       byte_done_c
);
  localparam int unsigned DIV_W = $clog2(CLKS_PER_BIT);

  bit_state_t       state;
  logic [DIV_W-1:0] div_q;
  logic [2:0]       bit_q;
  logic             stop_q;
  logic [7:0]       shreg_q;
  logic             parity_q;
  logic             bit_end_c;

  assign bit_end_c   = (div_q == DIV_W'(CLKS_PER_BIT - 1));
  // High in the final cycle of the final stop bit; a start here chains the next frame seamlessly
  assign byte_done_c = (state == BIT_STOP) && bit_end_c && (stop_q == 1'(STOP_BITS - 1));

  // Frame sequencer with baud divider; line and frame_busy are registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= BIT_IDLE;
      div_q      <= '0;
      bit_q      <= '0;
      stop_q     <= 1'b0;
      shreg_q    <= '0;
      parity_q   <= 1'b0;
      line       <= IDLE_LEVEL;
      frame_busy <= 1'b0;
    end else if (start && (state == BIT_IDLE || byte_done_c)) begin
      state      <= BIT_START;
      div_q      <= '0;
      shreg_q    <= byte_in;
      parity_q   <= ^byte_in;
      line       <= START_LEVEL;
      frame_busy <= 1'b1;
    end else if (byte_done_c) begin
      state      <= BIT_IDLE;
      div_q      <= '0;
      line       <= IDLE_LEVEL;
      frame_busy <= 1'b0;
    end else if (state != BIT_IDLE) begin
      if (!bit_end_c) begin
        div_q <= div_q + DIV_W'(1);
      end else begin
        div_q <= '0;
        unique case (state)
          BIT_START: begin
            state   <= BIT_DATA;
            bit_q   <= '0;
            line    <= shreg_q[0];
            shreg_q <= {1'b0, shreg_q[7:1]};
          end
          BIT_DATA: begin
            if (bit_q == 3'd7) begin
              if (PARITY_EN != 0) begin
                state <= BIT_PARITY;
                line  <= parity_q;
              end else begin
                state  <= BIT_STOP;
                stop_q <= 1'b0;
                line   <= IDLE_LEVEL;
              end
            end else begin
              bit_q   <= bit_q + 3'd1;
              line    <= shreg_q[0];
              shreg_q <= {1'b0, shreg_q[7:1]};
            end
          end
          BIT_PARITY: begin
            state  <= BIT_STOP;
            stop_q <= 1'b0;
            line   <= IDLE_LEVEL;
          end
          BIT_STOP: stop_q <= stop_q + 1'b1;
          default:  state  <= BIT_IDLE;
        endcase
      end
    end
  end
endmodule

// File: rtl/frame_transmitter.sv
// Packet framer: buffers a packet, feeds its bytes to the serialiser, inserts gaps, reports ready/done.
module frame_transmitter
  import tx_defs::*;
#(
  parameter int unsigned DATA_BYTES   = 8,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned PARITY_EN    = 0,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned GAP_CLKS     = 0,
  parameter int unsigned BYTE_MSB_1ST = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  frame_transmitter_if.slave bus
);
  localparam int unsigned LEN_W  = len_width(DATA_BYTES);
  localparam int unsigned GAP_W  = $clog2(GAP_CLKS + 2);
  localparam bit          NO_GAP = (GAP_CLKS == 0);

  pkt_state_t              state;
  logic [8*DATA_BYTES-1:0] pkt_q;
  logic [LEN_W-1:0]        len_q;
  logic [LEN_W-1:0]        idx_q;
  logic [GAP_W-1:0]        gap_q;
  logic                    ready_q;
  logic                    busy_q;
  logic                    done_q;

  logic                    accept_c;
  logic                    last_c;
  logic                    gap_end_c;
  logic                    start_c;
  logic [7:0]              byte_c;
  logic                    line;
  logic                    frame_busy;
  logic                    byte_done_c;

  // Byte i of an n-byte packet, honouring the configured send order
  function automatic logic [7:0] pick(input logic [8*DATA_BYTES-1:0] pkt,
                                      input logic [LEN_W-1:0] n,
                                      input logic [LEN_W-1:0] i);
    logic [LEN_W-1:0] sel;
    sel = (BYTE_MSB_1ST != 0) ? LEN_W'(n - i - LEN_W'(1)) : i;
    return 8'(pkt >> {sel, 3'b000});
  endfunction

  assign accept_c  = ready_q && bus.send && (bus.len != '0) && (bus.len <= LEN_W'(DATA_BYTES));
  assign last_c    = (idx_q == LEN_W'(len_q - LEN_W'(1)));
  assign gap_end_c = (gap_q == GAP_W'(GAP_CLKS - 1));

  // Byte launch: first byte straight from the bus on accept, later bytes from the buffer
  always_comb begin
    start_c = 1'b0;
    byte_c  = pick(bus.data, bus.len, LEN_W'(0));
    unique case (state)
      PKT_IDLE: start_c = accept_c;
      PKT_SEND: begin
        if (NO_GAP && byte_done_c && !last_c) begin
          start_c = 1'b1;
          byte_c  = pick(pkt_q, len_q, LEN_W'(idx_q + LEN_W'(1)));
        end
      end
      PKT_GAP: begin
        if (gap_end_c) begin
          start_c = 1'b1;
          byte_c  = pick(pkt_q, len_q, idx_q);
        end
      end
      default: start_c = 1'b0;
    endcase
  end

  // Packet FSM with registered ready/busy/done
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= PKT_IDLE;
      pkt_q   <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      gap_q   <= '0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        PKT_IDLE: begin
          if (accept_c) begin
            pkt_q   <= bus.data;
            len_q   <= bus.len;
            idx_q   <= '0;
            state   <= PKT_SEND;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        PKT_SEND: begin
          if (byte_done_c) begin
            if (last_c) begin
              state   <= PKT_IDLE;
              idx_q   <= '0;
              ready_q <= 1'b1;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              idx_q <= idx_q + LEN_W'(1);
              if (!NO_GAP) begin
                state <= PKT_GAP;
                gap_q <= '0;
              end
            end
          end
        end
        PKT_GAP: begin
          if (gap_end_c) state <= PKT_SEND;
          else           gap_q <= gap_q + GAP_W'(1);
        end
        default: state <= PKT_IDLE;
      endcase
    end
  end

  serial_byte_tx #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .PARITY_EN    (PARITY_EN),
    .STOP_BITS    (STOP_BITS)
  ) u_byte_tx (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start_c),
    .byte_in     (byte_c),
    .line        (line),
    .frame_busy  (frame_busy),
    .byte_done_c (byte_done_c)
  );

  assign bus.ready        = ready_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.transmission = frame_busy;
  assign bus.out_data     = line;
endmodule
